// File: rtl/nios_system_pio_pkg.sv
// Shared register map, edge-mode encodings and CONFIG field positions for the
// Nios PIO input/interrupt controller.
package nios_system_pio_pkg;

  localparam logic [1:0] REG_DATA     = 2'd0;
  localparam logic [1:0] REG_IRQ_MASK = 2'd1;
  localparam logic [1:0] REG_EDGE_CAP = 2'd2;
  localparam logic [1:0] REG_CONFIG   = 2'd3;

  localparam logic [1:0] EDGE_RISE = 2'b00;
  localparam logic [1:0] EDGE_FALL = 2'b01;
  localparam logic [1:0] EDGE_BOTH = 2'b10;

  localparam int unsigned CFG_MODE_LSB = 0;
  localparam int unsigned CFG_MODE_MSB = 1;
  localparam int unsigned CFG_DEB_EN   = 2;

  // Encoding 2'b11 is treated as both edges, same as EDGE_BOTH.
  function automatic logic [31:0] edge_select(input logic [1:0] mode,
                                              input logic [31:0] rise,
                                              input logic [31:0] fall);
    logic [31:0] sel;
    sel = '0;
    case (mode)
      EDGE_RISE: sel = rise;
      EDGE_FALL: sel = fall;
      default:   sel = rise | fall;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/nios_system_pio_debounce_bit.sv
// Single-bit debouncer: accepts a new level after DEB_TICKS consecutive stable
// ticks, or follows the input directly when disabled.
module nios_system_pio_debounce_bit #(
  parameter int DEB_TICKS = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic sync,
  input  logic en,
  output logic debounced,
  output logic debounced_next
);

  logic [7:0] cnt;
  logic [7:0] cnt_next;

  always_comb begin
    cnt_next       = cnt;
    debounced_next = debounced;
    if (!en) begin
      cnt_next       = '0;
      debounced_next = sync;
    end else if (sync == debounced) begin
      cnt_next = '0;
    end else if (tick) begin
      // Accept on the tick that would bring the count to DEB_TICKS.
      if (cnt == 8'(DEB_TICKS - 1)) begin
        debounced_next = sync;
        cnt_next       = '0;
      end else begin
        cnt_next = cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      debounced <= 1'b0;
    end else begin
      cnt       <= cnt_next;
      debounced <= debounced_next;
    end
  end

endmodule

// File: rtl/nios_system_pio_irq_ctrl.sv
// Avalon-MM input PIO: synchronise, debounce, edge-capture and raise a
// maskable level interrupt.
module nios_system_pio_irq_ctrl
  import nios_system_pio_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int TICK_DIV  = 50000,
  parameter int DEB_TICKS = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0]    presc;
  logic             tick;
  logic [WIDTH-1:0] sync1, sync2;
  logic [WIDTH-1:0] debounced, debounced_next;
  logic [WIDTH-1:0] edge_capture, edge_capture_next;
  logic [WIDTH-1:0] irq_mask;
  logic [1:0]       edge_mode;
  logic             deb_en;
  logic             wr;
  logic [31:0]      sel_edges;
  logic [31:0]      rd_mux;
  logic             unused_bits;

  assign wr   = chipselect & ~write_n;
  assign tick = (presc == PW'(TICK_DIV - 1));

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_deb
      nios_system_pio_debounce_bit #(
        .DEB_TICKS(DEB_TICKS)
      ) u_deb (
        .clk           (clk),
        .rst_n         (reset_n),
        .tick          (tick),
        .sync          (sync2[gi]),
        .en            (deb_en),
        .debounced     (debounced[gi]),
        .debounced_next(debounced_next[gi])
      );
    end
  endgenerate

  // Set is OR'd in after the W1C mask so a same-cycle edge wins over a clear.
  always_comb begin
    sel_edges = edge_select(edge_mode,
                            32'(debounced_next & ~debounced),
                            32'(~debounced_next & debounced));
    edge_capture_next = edge_capture;
    if (wr && address == REG_EDGE_CAP)
      edge_capture_next = edge_capture & ~writedata[WIDTH-1:0];
    edge_capture_next = edge_capture_next | sel_edges[WIDTH-1:0];
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      REG_DATA:     rd_mux = 32'(debounced);
      REG_IRQ_MASK: rd_mux = 32'(irq_mask);
      REG_EDGE_CAP: rd_mux = 32'(edge_capture);
      default: begin
        rd_mux[CFG_MODE_MSB:CFG_MODE_LSB] = edge_mode;
        rd_mux[CFG_DEB_EN]                = deb_en;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc        <= '0;
      sync1        <= '0;
      sync2        <= '0;
      edge_capture <= '0;
      irq_mask     <= '0;
      edge_mode    <= EDGE_RISE;
      deb_en       <= 1'b1;
      irq          <= 1'b0;
      readdata     <= '0;
    end else begin
      presc        <= tick ? '0 : presc + PW'(1);
      sync1        <= in_port;
      sync2        <= sync1;
      edge_capture <= edge_capture_next;
      if (wr && address == REG_IRQ_MASK)
        irq_mask <= writedata[WIDTH-1:0];
      if (wr && address == REG_CONFIG) begin
        edge_mode <= writedata[CFG_MODE_MSB:CFG_MODE_LSB];
        deb_en    <= writedata[CFG_DEB_EN];
      end
      irq      <= |(edge_capture & irq_mask);
      readdata <= rd_mux;
    end
  end

  assign unused_bits = ^{writedata, sel_edges};

endmodule

// File: tb/tb_nios_system_pio_irq_ctrl.sv
// Self-checking bench for nios_system_pio_irq_ctrl with a fast debounce
// configuration (TICK_DIV=4, DEB_TICKS=3).
module tb_nios_system_pio_irq_ctrl;
  import nios_system_pio_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [7:0]  in_port = '0;
  logic [31:0] readdata;
  logic        irq;

  int unsigned total = 0;
  int unsigned bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got;
  logic [31:0] want;

  always #5 clk = ~clk;

  nios_system_pio_irq_ctrl #(
    .WIDTH(8),
    .TICK_DIV(4),
    .DEB_TICKS(3)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .in_port(in_port),
    .readdata(readdata),
    .irq(irq)
  );

  // Called at a negedge; the write lands on the following posedge.
  task automatic do_write(input logic [1:0] a, input logic [31:0] d);
    address = a;
    writedata = d;
    chipselect = 1'b1;
    write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n = 1'b1;
  endtask

  task automatic do_read(input logic [1:0] a, output logic [31:0] d);
    address = a;
    @(negedge clk);
    d = readdata;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    do_write(REG_CONFIG, 32'h0);
    do_write(REG_IRQ_MASK, 32'hFF);
    in_port = 8'h01;
    repeat (5) @(negedge clk);
    do_read(REG_IRQ_MASK, got);
    reset_n = 1'b0;
    in_port = 8'h00;
    #1;
    total++;
    if (readdata !== 32'h0) begin bad++; $display("FAIL reset_readdata got=%h want=0", readdata); end
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b want=0", irq); end
    @(negedge clk);
    reset_n = 1'b1;
    exp_q.push_back(32'h4);
    do_read(REG_CONFIG, got); want = exp_q.pop_front(); total++;
    if (got !== want) begin bad++; $display("FAIL reset_config got=%h want=%h", got, want); end
    exp_q.push_back(32'h0);
    do_read(REG_IRQ_MASK, got); want = exp_q.pop_front(); total++;
    if (got !== want) begin bad++; $display("FAIL reset_mask got=%h want=%h", got, want); end
    exp_q.push_back(32'h0);
    do_read(REG_EDGE_CAP, got); want = exp_q.pop_front(); total++;
    if (got !== want) begin bad++; $display("FAIL reset_edgecap got=%h want=%h", got, want); end
  endtask

  task automatic test_bypass_rise;
    do_write(REG_CONFIG, 32'h0);
    do_write(REG_IRQ_MASK, 32'h1);
    repeat (3) @(negedge clk);
    in_port = 8'h01;
    repeat (3) @(negedge clk);
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL bypass_irq_early got=%b want=0", irq); end
    @(negedge clk);
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL bypass_irq_4clk got=%b want=1", irq); end
    exp_q.push_back(32'h1);
    do_read(REG_DATA, got); want = exp_q.pop_front(); total++;
    if (got !== want) begin bad++; $display("FAIL bypass_data got=%h want=%h", got, want); end
    exp_q.push_back(32'h1);
    do_read(REG_EDGE_CAP, got); want = exp_q.pop_front(); total++;
    if (got !== want) begin bad++; $display("FAIL bypass_edgecap got=%h want=%h", got, want); end
    do_write(REG_EDGE_CAP, 32'h1);
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL w1c_irq_hold got=%b want=1", irq); end
    @(negedge clk);
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL w1c_irq_drop got=%b want=0", irq); end
  endtask

  task automatic test_debounce;
    in_port = 8'h00;
    repeat (4) @(negedge clk);
    do_write(REG_EDGE_CAP, 32'hFF);
    do_write(REG_CONFIG, 32'h4);
    in_port = 8'h08;
    repeat (7) @(negedge clk);
    exp_q.push_back(32'h0);
    do_read(REG_DATA, got); want = exp_q.pop_front(); total++;
    if (got !== want) begin bad++; $display("FAIL deb_early got=%h want=%h", got, want); end
    repeat (12) @(negedge clk);
    exp_q.push_back(32'h08);
    do_read(REG_DATA, got); want = exp_q.pop_front(); total++;
    if (got !== want) begin bad++; $display("FAIL deb_accept got=%h want=%h", got, want); end
    in_port = 8'h28;
    repeat (5) @(negedge clk);
    in_port = 8'h08;
    repeat (20) @(negedge clk);
    exp_q.push_back(32'h08);
    do_read(REG_DATA, got); want = exp_q.pop_front(); total++;
    if (got !== want) begin bad++; $display("FAIL deb_glitch_data got=%h want=%h", got, want); end
    exp_q.push_back(32'h08);
    do_read(REG_EDGE_CAP, got); want = exp_q.pop_front(); total++;
    if (got !== want) begin bad++; $display("FAIL deb_glitch_cap got=%h want=%h", got, want); end
  endtask

  task automatic test_edge_modes;
    logic [7:0] pat[4];
    logic [1:0] mode[4];
    logic [31:0] expv[4];
    pat = '{8'h08, 8'h88, 8'h08, 8'h88};
    mode = '{2'b01, 2'b01, 2'b10, 2'b10};
    expv = '{32'h80, 32'h00, 32'h80, 32'h80};
    do_write(REG_CONFIG, 32'h0);
    in_port = 8'h88;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      do_write(REG_EDGE_CAP, 32'hFF);
      do_write(REG_CONFIG, {30'h0, mode[i]});
      in_port = pat[i];
      repeat (4) @(negedge clk);
      exp_q.push_back(expv[i]);
      do_read(REG_EDGE_CAP, got); want = exp_q.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL edge_mode_%0d got=%h want=%h", i, got, want); end
    end
    exp_q.push_back(32'h2);
    do_read(REG_CONFIG, got); want = exp_q.pop_front(); total++;
    if (got !== want) begin bad++; $display("FAIL edge_cfg_rb got=%h want=%h", got, want); end
  endtask

  task automatic test_set_clear_collision;
    do_write(REG_CONFIG, 32'h0);
    do_write(REG_IRQ_MASK, 32'h1);
    do_write(REG_EDGE_CAP, 32'hFF);
    in_port = 8'h89;
    repeat (4) @(negedge clk);
    exp_q.push_back(32'h01);
    do_read(REG_EDGE_CAP, got); want = exp_q.pop_front(); total++;
    if (got !== want) begin bad++; $display("FAIL coll_pre got=%h want=%h", got, want); end
    in_port = 8'h88;
    repeat (4) @(negedge clk);
    in_port = 8'h89;
    repeat (2) @(negedge clk);
    do_write(REG_EDGE_CAP, 32'h1);
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL coll_irq got=%b want=1", irq); end
    exp_q.push_back(32'h01);
    do_read(REG_EDGE_CAP, got); want = exp_q.pop_front(); total++;
    if (got !== want) begin bad++; $display("FAIL coll_cap got=%h want=%h", got, want); end
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL coll_irq_after got=%b want=1", irq); end
  endtask

  task automatic test_mask_gating;
    do_write(REG_IRQ_MASK, 32'h0);
    in_port = 8'h80;
    repeat (4) @(negedge clk);
    do_write(REG_EDGE_CAP, 32'hFF);
    in_port = 8'h8F;
    repeat (4) @(negedge clk);
    exp_q.push_back(32'h0F);
    do_read(REG_EDGE_CAP, got); want = exp_q.pop_front(); total++;
    if (got !== want) begin bad++; $display("FAIL mask_cap got=%h want=%h", got, want); end
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL mask_irq_off got=%b want=0", irq); end
    do_write(REG_IRQ_MASK, 32'h04);
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL mask_irq_same got=%b want=0", irq); end
    @(negedge clk);
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL mask_irq_on got=%b want=1", irq); end
    do_write(REG_IRQ_MASK, 32'h0);
    @(negedge clk);
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL mask_irq_clr got=%b want=0", irq); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    test_reset;
    test_bypass_rise;
    test_debounce;
    test_edge_modes;
    test_set_clear_collision;
    test_mask_gating;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
